// File: rtl/prv32_muldiv_seq_pkg.sv
// Shared definitions for the sequential RV32M multiply/divide unit.
//   op_e    : funct3 encodings of the eight M-extension operations
//   state_e : FSM state encoding (exported on the debug port)
//   is_div_op : true for DIV/DIVU/REM/REMU (funct3 bit 2)
package prv32_muldiv_seq_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic is_div_op(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/prv32_muldiv_seq_if.sv
// Request/response bus of the multiply/divide unit.
//   master : issuing pipeline (drives flush, request fields, out_ready)
//   slave  : the unit (drives in_ready, out_valid, result, busy)
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. A source holds valid and its payload stable until that
// edge; the sink's ready never depends combinationally on the source's
// valid. Request side: in_valid/in_ready with op, a, b. Response side:
// out_valid/out_ready with result. flush kills any in-flight op.
interface prv32_muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output flush, in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  flush, in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/prv32_muldiv_seq_sign_cond.sv
// Combinational operand conditioning for the multiply/divide unit.
//   op       : funct3 of the request
//   a, b     : raw rs1 / rs2 operands
//   sa, sb   : operand signs that matter for this op (0 for unsigned roles)
//   ma, mb   : operand magnitudes (two's-complement negated when sign set)
//   fast     : op completes without iterating (div by zero / signed overflow)
//   fast_val : architectural result for the fast path
module prv32_muldiv_seq_sign_cond
  import prv32_muldiv_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            sa,
  output logic            sb,
  output logic [XLEN-1:0] ma,
  output logic [XLEN-1:0] mb,
  output logic            fast,
  output logic [XLEN-1:0] fast_val
);

  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  op_e opc;
  logic signed_div;

  always_comb begin
    opc        = op_e'(op);
    sa         = 1'b0;
    sb         = 1'b0;
    fast       = 1'b0;
    fast_val   = '0;
    signed_div = (opc == OP_DIV) || (opc == OP_REM);

    unique case (opc)
      OP_MULH, OP_DIV, OP_REM: begin
        sa = a[XLEN-1];
        sb = b[XLEN-1];
      end
      // b is an unsigned operand for MULHSU, so only a carries a sign
      OP_MULHSU: sa = a[XLEN-1];
      default: ;
    endcase

    ma = sa ? (~a + 1'b1) : a;
    mb = sb ? (~b + 1'b1) : b;

    if (is_div_op(op)) begin
      if (b == '0) begin
        // op[1] separates REM/REMU (returns dividend) from DIV/DIVU (all ones)
        fast     = 1'b1;
        fast_val = op[1] ? a : '1;
      end else if (signed_div && (a == MIN_INT) && (b == '1)) begin
        fast     = 1'b1;
        fast_val = op[1] ? '0 : MIN_INT;
      end
    end
  end

endmodule

// File: rtl/prv32_muldiv_seq.sv
// Iterative RV32M multiply/divide unit, one result bit per clock.
//   clk, rst  : rising-edge clock, asynchronous active-high reset
//   bus       : request/response bus (slave side), see prv32_muldiv_seq_if
//   dbg_state : current FSM state, for observation only
// Multiply is shift-add into a 2*XLEN accumulator; divide is restoring
// division sharing the same register (remainder high half, dividend/quotient
// low half). Signs are stripped on accept and re-applied in FIX.
// Divide-by-zero and signed overflow skip straight to DONE.
module prv32_muldiv_seq
  import prv32_muldiv_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  prv32_muldiv_seq_if.slave   bus,
  output state_e              dbg_state
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam int IDX_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

  state_e            state;
  logic [CNT_W-1:0]  count;
  op_e               op_q;
  logic              sa_q;
  logic              sb_q;
  logic [XLEN-1:0]   ma;
  logic [XLEN-1:0]   mb;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   result_q;
  logic              out_valid_q;
  logic              busy_q;

  // Operand conditioning on the live request fields
  logic            c_sa;
  logic            c_sb;
  logic [XLEN-1:0] c_ma;
  logic [XLEN-1:0] c_mb;
  logic            c_fast;
  logic [XLEN-1:0] c_fast_val;

  prv32_muldiv_seq_sign_cond #(.XLEN(XLEN)) u_sign_cond (
    .op       (bus.op),
    .a        (bus.a),
    .b        (bus.b),
    .sa       (c_sa),
    .sb       (c_sb),
    .ma       (c_ma),
    .mb       (c_mb),
    .fast     (c_fast),
    .fast_val (c_fast_val)
  );

  // One iteration of either algorithm
  logic [IDX_W-1:0]  bit_idx;
  logic [2*XLEN-1:0] mul_add;
  logic [XLEN:0]     rem_sh;
  logic [XLEN:0]     rem_diff;
  logic              rem_ge;

  always_comb begin
    bit_idx  = count[IDX_W-1:0];
    mul_add  = mb[bit_idx] ? ({{XLEN{1'b0}}, ma} << bit_idx) : '0;
    // remainder shifted left with the next dividend bit (acc MSB of low half)
    rem_sh   = acc[2*XLEN-1:XLEN-1];
    rem_diff = rem_sh - {1'b0, mb};
    // The remainder stays below |b| before the shift, so rem_sh < 2*|b| and
    // the difference's top bit is clear exactly when rem_sh >= |b|.
    rem_ge   = ~rem_diff[XLEN];
  end

  // Sign fix-up and result selection
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quot_s;
  logic [XLEN-1:0]   rem_s;
  logic [XLEN-1:0]   fix_val;

  always_comb begin
    prod_s = (sa_q ^ sb_q) ? (~acc + 1'b1) : acc;
    quot_s = (sa_q ^ sb_q) ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
    rem_s  = sa_q ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];
    unique case (op_q)
      OP_MUL:                      fix_val = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_val = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             fix_val = quot_s;
      default:                     fix_val = rem_s;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      count       <= '0;
      op_q        <= OP_MUL;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      ma          <= '0;
      mb          <= '0;
      acc         <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (bus.flush) begin
      // Kill wins over everything; result keeps its last presented value
      state       <= ST_IDLE;
      count       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            op_q  <= op_e'(bus.op);
            sa_q  <= c_sa;
            sb_q  <= c_sb;
            ma    <= c_ma;
            mb    <= c_mb;
            count <= '0;
            if (c_fast) begin
              result_q    <= c_fast_val;
              out_valid_q <= 1'b1;
              state       <= ST_DONE;
            end else begin
              acc    <= is_div_op(bus.op) ? {{XLEN{1'b0}}, c_ma} : '0;
              busy_q <= 1'b1;
              state  <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (is_div_op(op_q)) begin
            acc <= {(rem_ge ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0]),
                    acc[XLEN-2:0], rem_ge};
          end else begin
            acc <= acc + mul_add;
          end
          count <= count + 1'b1;
          if (count == LAST_ITER) state <= ST_FIX;
        end
        ST_FIX: begin
          result_q    <= fix_val;
          out_valid_q <= 1'b1;
          busy_q      <= 1'b0;
          state       <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.busy      = busy_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_prv32_muldiv_seq.sv
module tb_prv32_muldiv_seq;
  import prv32_muldiv_seq_pkg::*;

  localparam int XLEN = 32;
  localparam logic [31:0] MIN_INT = 32'h8000_0000;

  logic   clk;
  logic   rst;
  state_e dbg_state;
  int     tests_run;
  int     fails;
  logic [31:0] last_res;

  prv32_muldiv_seq_if #(.XLEN(XLEN)) bus ();

  prv32_muldiv_seq #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic signed [31:0] sq;
    case (op)
      3'b000: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'b001: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      3'b010: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
      3'b011: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MIN_INT && b == 32'hFFFF_FFFF) return MIN_INT;
        sq = $signed(a) / $signed(b);
        return sq;
      end
      3'b101: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'b110: begin
        if (b == 0) return a;
        if (a == MIN_INT && b == 32'hFFFF_FFFF) return 32'h0;
        sq = $signed(a) % $signed(b);
        return sq;
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == 3'b100 || op == 3'b110) && a == MIN_INT && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 2;
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return MIN_INT;
      3: return 32'h1;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns #1 after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = $urandom;
    bus.b        = $urandom;
    bus.op       = 3'($urandom_range(0, 7));
  endtask

  // Counts negedges after the accept edge until out_valid (bounded).
  task automatic wait_result(output logic [31:0] res, output int lat, output int busy_n);
    lat    = 0;
    busy_n = 0;
    res    = '0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (bus.busy) busy_n++;
      if (bus.out_valid) begin
        res = bus.result;
        break;
      end
    end
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output int busy_n);
    issue(op, a, b);
    wait_result(res, lat, busy_n);
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = 3'b000;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    tests_run++;
    if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    tests_run++;
    if (bus.result !== 32'h0) begin fails++; $display("FAIL reset_result: got %h want 0", bus.result); end
    tests_run++;
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    tests_run++;
    if (dbg_state !== ST_IDLE) begin fails++; $display("FAIL reset_state: got %0d want IDLE", dbg_state); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [2:0]  t_op[12] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b100, 3'b110, 3'b101, 3'b111,
                              3'b100, 3'b111, 3'b100, 3'b110};
    logic [31:0] t_a[12]  = '{32'd7, MIN_INT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                              32'd100, 32'd100, 32'd5, 32'd5, MIN_INT, MIN_INT};
    logic [31:0] t_b[12]  = '{32'hFFFF_FFFD, MIN_INT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                              32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] t_exp[12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                               32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, MIN_INT, 32'h0};
    int          t_lat[12] = '{34, 34, 34, 34, 34, 34, 34, 34, 1, 1, 1, 1};
    logic [31:0] res;
    int lat, busy_n;
    for (int i = 0; i < 12; i++) begin
      do_op(t_op[i], t_a[i], t_b[i], res, lat, busy_n);
      tests_run++;
      if (res !== t_exp[i]) begin
        fails++;
        $display("FAIL directed_result[%0d] op=%0d a=%h b=%h: got %h want %h", i, t_op[i], t_a[i], t_b[i], res, t_exp[i]);
      end
      tests_run++;
      if (lat != t_lat[i]) begin
        fails++;
        $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, t_lat[i]);
      end
      if (i == 0) begin
        tests_run++;
        if (busy_n != 33) begin fails++; $display("FAIL directed_busy_cycles: got %0d want 33", busy_n); end
      end
      last_res = t_exp[i];
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b, res, exp;
    int lat, busy_n, exp_lat;
    for (int i = 0; i < 160; i++) begin
      op      = 3'($urandom_range(0, 7));
      a       = rand_operand();
      b       = rand_operand();
      exp     = model(op, a, b);
      exp_lat = model_lat(op, a, b);
      do_op(op, a, b, res, lat, busy_n);
      tests_run++;
      if (res !== exp) begin
        fails++;
        $display("FAIL random_result[%0d] op=%0d a=%h b=%h: got %h want %h", i, op, a, b, res, exp);
      end
      tests_run++;
      if (lat != exp_lat) begin
        fails++;
        $display("FAIL random_latency[%0d] op=%0d: got %0d want %0d", i, op, lat, exp_lat);
      end
      last_res = exp;
    end
  endtask

  task automatic test_backpressure();
    logic [2:0]  op;
    logic [31:0] a, b, res, exp;
    int lat, busy_n;
    op  = 3'($urandom_range(0, 7));
    a   = $urandom;
    b   = $urandom;
    exp = model(op, a, b);
    bus.out_ready = 1'b0;
    issue(op, a, b);
    wait_result(res, lat, busy_n);
    tests_run++;
    if (res !== exp) begin fails++; $display("FAIL bp_result: got %h want %h", res, exp); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests_run++;
      if (bus.out_valid !== 1'b1 || bus.result !== exp || bus.in_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold[%0d]: got v=%b r=%h rdy=%b want v=1 r=%h rdy=0", i, bus.out_valid, bus.result, bus.in_ready, exp);
      end
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_release: got v=%b rdy=%b want v=0 rdy=1", bus.out_valid, bus.in_ready);
    end
    // back-to-back: request presented in the very cycle after completion
    a   = $urandom;
    b   = 32'($urandom_range(1, 1000));
    exp = model(3'b101, a, b);
    issue(3'b101, a, b);
    wait_result(res, lat, busy_n);
    tests_run++;
    if (res !== exp || lat != 34) begin
      fails++;
      $display("FAIL b2b_divu: got %h lat %0d want %h lat 34", res, lat, exp);
    end
    last_res = exp;
    @(negedge clk);
  endtask

  task automatic test_flush();
    int seen;
    issue(3'b000, $urandom, $urandom);
    // the accept edge left count=0; ten more edges reach iteration 10
    repeat (10) @(negedge clk);
    tests_run++;
    if (dbg_state !== ST_CALC) begin fails++; $display("FAIL flush_pre_state: got %0d want CALC", dbg_state); end
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    tests_run++;
    if (dbg_state !== ST_IDLE || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL flush_idle: got st=%0d rdy=%b busy=%b want IDLE 1 0", dbg_state, bus.in_ready, bus.busy);
    end
    tests_run++;
    if (bus.result !== last_res) begin fails++; $display("FAIL flush_result_kept: got %h want %h", bus.result, last_res); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    tests_run++;
    if (seen != 0) begin fails++; $display("FAIL flush_no_valid: got %0d valid cycles want 0", seen); end
    // flush together with a request in IDLE: request is ignored
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.op       = 3'b000;
    bus.a        = 32'd9;
    bus.b        = 32'd9;
    @(negedge clk);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    tests_run++;
    if (dbg_state !== ST_IDLE || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL flush_ignores_req: got st=%0d busy=%b want IDLE 0", dbg_state, bus.busy);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] res;
    int lat, busy_n;
    issue(3'b001, $urandom, $urandom);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.result !== 32'h0 ||
        bus.in_ready !== 1'b1 || dbg_state !== ST_IDLE) begin
      fails++;
      $display("FAIL async_reset: got v=%b busy=%b r=%h rdy=%b st=%0d want 0 0 0 1 IDLE",
               bus.out_valid, bus.busy, bus.result, bus.in_ready, dbg_state);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_op(3'b000, 32'd3, 32'd4, res, lat, busy_n);
    tests_run++;
    if (res !== 32'd12 || lat != 34) begin
      fails++;
      $display("FAIL post_reset_mul: got %h lat %0d want 0000000c lat 34", res, lat);
    end
  endtask

  initial begin
    tests_run = 0;
    fails     = 0;
    last_res  = '0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_flush();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
